// File: rtl/player_motion_if.sv
// player_motion_if: step strobe, keys and collision flags in; action, facing and position out
interface player_motion_if #(parameter int POS_W = 10);
  logic             step_en_i;
  logic [3:0]       keys_i;
  logic [3:0]       collide_i;
  logic [1:0]       action_o;
  logic             direction_o;
  logic [POS_W-1:0] pos_x_o;
  logic [POS_W-1:0] pos_y_o;
  logic [2:0]       jumps_used_o;
  modport master (output step_en_i, keys_i, collide_i,
                  input  action_o, direction_o, pos_x_o, pos_y_o, jumps_used_o);
  modport slave  (input  step_en_i, keys_i, collide_i,
                  output action_o, direction_o, pos_x_o, pos_y_o, jumps_used_o);
endinterface

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: turns debounced keys and per-side collision flags into action, facing and pixel position
module player_motion_ctrl #(
  parameter int POS_W       = 10,
  parameter int PER_W       = 8,
  parameter int INIT_X      = 200,
  parameter int INIT_Y      = 556,
  parameter int X_MAX       = 799,
  parameter int X_PERIOD    = 200,
  parameter int JUMP_PERIOD = 42,
  parameter int APEX_PERIOD = 128,
  parameter int FALL_PERIOD = 128,
  parameter int TERM_PERIOD = 42,
  parameter int MAX_JUMPS   = 2,
  parameter int VAR_JUMP    = 1
) (
  input logic            clk,
  input logic            rst,
  player_motion_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, JUMP, FALL} act_e;
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
  localparam logic [PER_W-1:0] PER_MAX = '1;
  localparam logic [PER_W-1:0] JUMP_P  = PER_W'(JUMP_PERIOD);
  localparam logic [PER_W-1:0] APEX_P  = PER_W'(APEX_PERIOD);
  localparam logic [PER_W-1:0] FALL_P  = PER_W'(FALL_PERIOD);
  localparam logic [PER_W-1:0] TERM_P  = PER_W'(TERM_PERIOD);
  localparam logic [PER_W-1:0] X_P_M1  = PER_W'(X_PERIOD - 1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [POS_W-1:0] POS_MAX = '1;
  localparam logic [POS_W-1:0] X_LIM   = POS_W'(X_MAX);
  act_e             act_q, act_d;
  logic             dir_q, dir_d, jump_prev_q;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]       ju_q, ju_d;
  logic [PER_W-1:0] rise_q, rise_d, fall_q, fall_d, vcnt_q, vcnt_d, hcnt_q, hcnt_d;
  logic jump, drop, left, right, c_up, c_down, c_left, c_right;
  logic jump_edge, lr, grounded, cut, air_jump, launch, rev, hrun, hmove;
  assign {jump, drop, left, right}       = bus.keys_i;
  assign {c_up, c_down, c_left, c_right} = bus.collide_i;
  assign jump_edge = jump & ~jump_prev_q;
  assign lr        = left ^ right;
  assign grounded  = c_down & (act_q != JUMP);
  assign cut       = (act_q == JUMP) & (c_up | drop | ((VAR_JUMP != 0) & ~jump) | (rise_q >= APEX_P));
  assign air_jump  = ((act_q == JUMP) | (act_q == FALL)) & jump_edge & (ju_q < 3'(MAX_JUMPS));
  assign launch    = grounded ? jump_edge : ~cut & air_jump;
  // a reversal restarts the horizontal count instead of spending it in the new direction
  assign dir_d = lr ? right : dir_q;
  assign rev   = lr & (right != dir_q);
  assign hrun  = lr & ~(left ? c_left : c_right) & ~rev;
  assign hmove = hrun & (hcnt_q == X_P_M1);
  assign hcnt_d = (hrun & ~hmove) ? hcnt_q + PER_ONE : '0;
  assign x_d = ~hmove ? x_q :
               dir_d  ? ((x_q >= X_LIM) ? X_LIM : x_q + POS_ONE) :
                        ((x_q == '0) ? '0 : x_q - POS_ONE);
  always_comb begin
    act_d  = act_q;
    ju_d   = ju_q;
    rise_d = rise_q;
    fall_d = fall_q;
    y_d    = y_q;
    vcnt_d = '0;
    if (grounded) begin
      act_d = launch ? JUMP : lr ? RUN : IDLE;
      ju_d  = launch ? 3'd1 : 3'd0;
    end else if (act_q == IDLE || act_q == RUN) begin
      act_d  = FALL;
      fall_d = FALL_P;
      ju_d   = 3'd1;
    end else if (cut) begin
      act_d  = FALL;
      fall_d = FALL_P;
    end else if (launch) begin
      act_d = JUMP;
      ju_d  = ju_q + 3'd1;
    end else if (act_q == JUMP) begin
      vcnt_d = (vcnt_q + PER_ONE == rise_q) ? '0 : vcnt_q + PER_ONE;
      y_d    = (vcnt_q + PER_ONE == rise_q) ? ((y_q == '0) ? '0 : y_q - POS_ONE) : y_q;
      rise_d = (vcnt_q + PER_ONE == rise_q) ? ((rise_q == PER_MAX) ? PER_MAX : rise_q + PER_ONE) : rise_q;
    end else begin
      vcnt_d = (vcnt_q + PER_ONE == fall_q) ? '0 : vcnt_q + PER_ONE;
      y_d    = (vcnt_q + PER_ONE == fall_q) ? ((y_q == POS_MAX) ? POS_MAX : y_q + POS_ONE) : y_q;
      fall_d = (vcnt_q + PER_ONE == fall_q) ? ((fall_q > TERM_P) ? fall_q - PER_ONE : TERM_P) : fall_q;
    end
    if (launch) begin
      rise_d = JUMP_P;
      y_d    = (y_q == '0) ? '0 : y_q - POS_ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q       <= IDLE;
      dir_q       <= 1'b1;
      x_q         <= POS_W'(INIT_X);
      y_q         <= POS_W'(INIT_Y);
      ju_q        <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      vcnt_q      <= '0;
      hcnt_q      <= '0;
      jump_prev_q <= 1'b0;
    end else if (bus.step_en_i) begin
      act_q       <= act_d;
      dir_q       <= dir_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ju_q        <= ju_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      vcnt_q      <= vcnt_d;
      hcnt_q      <= hcnt_d;
      jump_prev_q <= jump;
    end
  end
  assign bus.action_o     = act_q;
  assign bus.direction_o  = dir_q;
  assign bus.pos_x_o      = x_q;
  assign bus.pos_y_o      = y_q;
  assign bus.jumps_used_o = ju_q;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: scenario tasks with a queue of expected states, one default DUT and one with X_PERIOD=1
module tb_player_motion_ctrl;
  typedef struct packed {
    logic [1:0] act;
    logic       dir;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] ju;
  } st_t;
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, JUMP = 2'b10, FALL = 2'b11;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  st_t   exp_q[$];
  string name_q[$];
  st_t   e;
  string n;
  player_motion_if #(.POS_W(10)) bus ();
  player_motion_if #(.POS_W(10)) fbus ();
  player_motion_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  player_motion_ctrl #(.X_PERIOD(1)) dut_fast (.clk(clk), .rst(rst), .bus(fbus));
  st_t obs_m, obs_f;
  assign obs_m = {bus.action_o, bus.direction_o, bus.pos_x_o, bus.pos_y_o, bus.jumps_used_o};
  assign obs_f = {fbus.action_o, fbus.direction_o, fbus.pos_x_o, fbus.pos_y_o, fbus.jumps_used_o};
  always #5 clk = ~clk;
  function automatic string fmt(input st_t s);
    return $sformatf("act=%0d dir=%0d x=%0d y=%0d jumps=%0d", s.act, s.dir, s.x, s.y, s.ju);
  endfunction
  task automatic expect_st(input string nm, input logic [1:0] a, input logic d, input int x, input int y, input int j);
    exp_q.push_back({a, d, 10'(x), 10'(y), 3'(j)});
    name_q.push_back(nm);
  endtask
  task automatic do_reset();
    bus.step_en_i = 1'b0; bus.keys_i = 4'b0000; bus.collide_i = 4'b0100;
    fbus.step_en_i = 1'b0; fbus.keys_i = 4'b0000; fbus.collide_i = 4'b0100;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic step_m(input logic [3:0] k, input logic [3:0] c);
    bus.keys_i = k; bus.collide_i = c; bus.step_en_i = 1'b1;
    @(posedge clk); #1;
    bus.step_en_i = 1'b0;
  endtask
  task automatic step_f(input logic [3:0] k, input logic [3:0] c);
    fbus.keys_i = k; fbus.collide_i = c; fbus.step_en_i = 1'b1;
    @(posedge clk); #1;
    fbus.step_en_i = 1'b0;
  endtask
  task automatic test_reset();
    expect_st("reset_state", IDLE, 1, 200, 556, 0);
    do_reset();
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_m !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_m), fmt(e)); end
    expect_st("ledge_fall", FALL, 0, 200, 556, 1);
    step_m(4'b0010, 4'b0000);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_m !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_m), fmt(e)); end
    for (int i = 0; i < 3; i++) step_m(4'b0000, 4'b0000);
    expect_st("reset_mid_fall", IDLE, 1, 200, 556, 0);
    bus.step_en_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_m !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_m), fmt(e)); end
  endtask
  task automatic test_run();
    do_reset();
    expect_st("run_first", RUN, 1, 200, 556, 0);
    step_m(4'b0001, 4'b0100);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_m !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_m), fmt(e)); end
    expect_st("run_199", RUN, 1, 200, 556, 0);
    for (int i = 1; i < 199; i++) step_m(4'b0001, 4'b0100);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_m !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_m), fmt(e)); end
    expect_st("run_200", RUN, 1, 201, 556, 0);
    step_m(4'b0001, 4'b0100);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_m !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_m), fmt(e)); end
    expect_st("run_400", RUN, 1, 202, 556, 0);
    for (int i = 200; i < 400; i++) step_m(4'b0001, 4'b0100);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_m !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_m), fmt(e)); end
  endtask
  task automatic test_full_jump();
    int steps;
    do_reset();
    expect_st("jump_launch", JUMP, 1, 200, 555, 1);
    step_m(4'b1000, 4'b0100);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_m !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_m), fmt(e)); end
    // rise periods 42..127 take 7267 steps, one more step to notice the apex
    expect_st("jump_apex", FALL, 1, 200, 469, 1);
    steps = 0;
    while (bus.action_o == JUMP && steps < 9000) begin
      step_m(4'b1000, 4'b0000);
      steps++;
    end
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_m !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_m), fmt(e)); end
    checks++;
    if (steps !== 7268) begin errors++; $display("FAIL jump_apex_steps: got %0d, want 7268", steps); end
  endtask
  task automatic test_var_jump();
    do_reset();
    expect_st("tap_step10", JUMP, 1, 200, 555, 1);
    step_m(4'b1000, 4'b0100);
    for (int i = 2; i <= 10; i++) step_m(4'b1000, 4'b0000);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_m !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_m), fmt(e)); end
    expect_st("tap_release", FALL, 1, 200, 555, 1);
    step_m(4'b0000, 4'b0000);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_m !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_m), fmt(e)); end
  endtask
  task automatic test_air_jump();
    logic [3:0] k[7] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
    logic [3:0] c[7] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    do_reset();
    expect_st("air_s1_launch",  JUMP, 1, 200, 555, 1);
    expect_st("air_s2_fall",    FALL, 1, 200, 555, 1);
    expect_st("air_s3_second",  JUMP, 1, 200, 554, 2);
    expect_st("air_s4_fall",    FALL, 1, 200, 554, 2);
    expect_st("air_s5_ignored", FALL, 1, 200, 554, 2);
    expect_st("air_s6_land",    IDLE, 1, 200, 554, 0);
    expect_st("air_s7_rejump",  JUMP, 1, 200, 553, 1);
    for (int i = 0; i < 7; i++) begin
      step_m(k[i], c[i]);
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs_m !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_m), fmt(e)); end
    end
  endtask
  task automatic test_clamp_freeze();
    do_reset();
    expect_st("fast_reach_max", RUN, 1, 799, 556, 0);
    for (int i = 0; i < 599; i++) step_f(4'b0001, 4'b0100);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_f !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_f), fmt(e)); end
    expect_st("clamp_right", RUN, 1, 799, 556, 0);
    for (int i = 0; i < 20; i++) step_f(4'b0001, 4'b0100);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_f !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_f), fmt(e)); end
    expect_st("freeze_50", RUN, 1, 799, 556, 0);
    fbus.keys_i = 4'b1010; fbus.collide_i = 4'b0000; fbus.step_en_i = 1'b0;
    for (int i = 0; i < 50; i++) begin @(posedge clk); #1; end
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_f !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_f), fmt(e)); end
    do_reset();
    expect_st("clamp_left", RUN, 0, 0, 556, 0);
    for (int i = 0; i < 250; i++) step_f(4'b0010, 4'b0100);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if (obs_f !== e) begin errors++; $display("FAIL %s: got %s, want %s", n, fmt(obs_f), fmt(e)); end
  endtask
  initial begin
    test_reset();
    test_run();
    test_full_jump();
    test_var_jump();
    test_air_jump();
    test_clamp_freeze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
